// File: rtl/mux5_rr_arbiter_pkg.sv
// Shared definitions for the round-robin register-destination arbiter:
// state encoding, address width and the round-robin pick function.
package mux5_rr_arbiter_pkg;

    localparam int ADDR_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GNT_A = 2'b01;
    localparam logic [1:0] ST_GNT_B = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_GNT_A = ST_GNT_A,
        S_GNT_B = ST_GNT_B
    } arb_state_t;

    // Round-robin decision: a lone requester wins; on a tie the requester
    // that did not own the path last wins (last: 0 = A, 1 = B).
    function automatic logic pick_a(input logic req_a, input logic req_b, input logic last);
        return req_a & (~req_b | last);
    endfunction

endpackage

// File: rtl/mux5_rr_arbiter_fivebit_mux.sv
// Two-input register-destination select mux: sel = 1 routes a, sel = 0 routes b.
module fivebit_mux
    import mux5_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = ADDR_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter sharing one fivebit_mux between requesters A and B.
// The granted address is captured into out_addr and held until the consumer
// acknowledges; on acknowledge a pending request is granted in the same edge.
module mux5_rr_arbiter
    import mux5_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] addr_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] addr_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_addr,
    input  logic             out_ack
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_last;
    logic             w_last_next;
    logic             w_sel;
    logic             w_load;
    logic             w_accept;
    logic             w_any_req;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_addr;
    logic [WIDTH-1:0] w_mux_y;

    fivebit_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (addr_a),
        .b   (addr_b),
        .sel (w_sel),
        .y   (w_mux_y)
    );

    assign w_accept  = r_out_valid & out_ack;
    assign w_any_req = req_a | req_b;

    // Next-state, next-owner, mux select and output-load decision.
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_sel        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel = pick_a(req_a, req_b, r_last);
                if (w_any_req) begin
                    w_state_next = w_sel ? S_GNT_A : S_GNT_B;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_GNT_A: begin
                if (w_accept) begin
                    // Priority already reflects A as the latest owner.
                    w_last_next = 1'b0;
                    w_sel       = pick_a(req_a, req_b, 1'b0);
                    if (w_any_req) begin
                        w_state_next = w_sel ? S_GNT_A : S_GNT_B;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_sel = 1'b1;
                end
            end
            S_GNT_B: begin
                if (w_accept) begin
                    w_last_next = 1'b1;
                    w_sel       = pick_a(req_a, req_b, 1'b1);
                    if (w_any_req) begin
                        w_state_next = w_sel ? S_GNT_A : S_GNT_B;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_sel = 1'b0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_sel        = 1'b0;
            end
        endcase
    end

    // State and last-owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    // Registered grant, valid and captured address outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            r_gnt_a     <= (w_state_next == S_GNT_A);
            r_gnt_b     <= (w_state_next == S_GNT_B);
            r_out_valid <= (w_state_next != S_IDLE);
            if (w_load) begin
                r_out_addr <= w_mux_y;
            end else begin
                r_out_addr <= r_out_addr;
            end
        end
    end

    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign sel       = w_sel;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed self-checking bench for mux5_rr_arbiter.
module tb_mux5_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic [4:0] addr_a;
    logic       req_b;
    logic [4:0] addr_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic       out_valid;
    logic [4:0] out_addr;
    logic       out_ack;

    int checks = 0;
    int errors = 0;

    mux5_rr_arbiter #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .addr_a    (addr_a),
        .req_b     (req_b),
        .addr_b    (addr_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_ack   (out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ga, input logic gb,
                              input logic v, input logic [4:0] addr);
        check({tag, ".gnt_a"}, 32'(gnt_a), 32'(ga));
        check({tag, ".gnt_b"}, 32'(gnt_b), 32'(gb));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".out_addr"}, 32'(out_addr), 32'(addr));
    endtask

    initial begin
        rst     = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        addr_a  = 5'd0;
        addr_b  = 5'd0;
        out_ack = 1'b0;

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 5'b00000);
        check("reset.sel", 32'(sel), 32'd0);
        step();
        #2 rst = 1'b0;
        step();

        // Ack while idle is ignored
        out_ack = 1'b1;
        step();
        check_outs("idle_ack", 1'b0, 1'b0, 1'b0, 5'b00000);
        out_ack = 1'b0;

        // Single request from A
        req_a  = 1'b1;
        addr_a = 5'b10101;
        #1;
        check("single.sel_idle", 32'(sel), 32'd1);
        step();
        check_outs("single", 1'b1, 1'b0, 1'b1, 5'b10101);
        check("single.sel", 32'(sel), 32'd1);
        addr_a = 5'b10001;
        step();
        check_outs("single_hold", 1'b1, 1'b0, 1'b1, 5'b10101);
        step();
        check_outs("single_hold2", 1'b1, 1'b0, 1'b1, 5'b10101);
        // Accept while A still requests: A re-granted with its new address
        out_ack = 1'b1;
        step();
        check_outs("single_regrant", 1'b1, 1'b0, 1'b1, 5'b10001);
        req_a = 1'b0;
        step();
        check_outs("single_done", 1'b0, 1'b0, 1'b0, 5'b10001);
        out_ack = 1'b0;

        // Reset so the tie starts from reset priority
        #2 rst = 1'b1;
        #1;
        check_outs("reset2", 1'b0, 1'b0, 1'b0, 5'b00000);
        #2 rst = 1'b0;

        // Tie with continuous ack: strict alternation A, B, A, B
        req_a   = 1'b1;
        req_b   = 1'b1;
        addr_a  = 5'b10000;
        addr_b  = 5'b11111;
        out_ack = 1'b1;
        #1;
        check("tie.sel_idle", 32'(sel), 32'd1);
        step();
        check_outs("tie1_A", 1'b1, 1'b0, 1'b1, 5'b10000);
        check("tie1.sel", 32'(sel), 32'd0);
        step();
        check_outs("tie2_B", 1'b0, 1'b1, 1'b1, 5'b11111);
        check("tie2.sel", 32'(sel), 32'd1);
        step();
        check_outs("tie3_A", 1'b1, 1'b0, 1'b1, 5'b10000);
        step();
        check_outs("tie4_B", 1'b0, 1'b1, 1'b1, 5'b11111);
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        check_outs("tie_end", 1'b0, 1'b0, 1'b0, 5'b11111);
        out_ack = 1'b0;

        // B alone
        req_b  = 1'b1;
        addr_b = 5'b01011;
        #1;
        check("b_alone.sel_idle", 32'(sel), 32'd0);
        step();
        check_outs("b_alone", 1'b0, 1'b1, 1'b1, 5'b01011);
        check("b_alone.sel", 32'(sel), 32'd0);
        out_ack = 1'b1;
        req_b   = 1'b0;
        step();
        check_outs("b_alone_done", 1'b0, 1'b0, 1'b0, 5'b01011);
        out_ack = 1'b0;

        // Back-to-back: B waits behind A, then takes over with no bubble
        req_a  = 1'b1;
        addr_a = 5'b00110;
        step();
        check_outs("b2b_A", 1'b1, 1'b0, 1'b1, 5'b00110);
        req_b  = 1'b1;
        addr_b = 5'b11001;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("b2b_hold", 1'b1, 1'b0, 1'b1, 5'b00110);
            check("b2b_hold.sel", 32'(sel), 32'd1);
        end
        out_ack = 1'b1;
        #1;
        check("b2b.sel_accept", 32'(sel), 32'd0);
        step();
        check_outs("b2b_B", 1'b0, 1'b1, 1'b1, 5'b11001);
        out_ack = 1'b0;
        req_a   = 1'b0;
        step();
        check_outs("b2b_B_hold", 1'b0, 1'b1, 1'b1, 5'b11001);

        // Reset mid-grant in GNT_B, then tie resolves to A
        #2 rst = 1'b1;
        #1;
        check_outs("midreset", 1'b0, 1'b0, 1'b0, 5'b00000);
        req_a  = 1'b1;
        req_b  = 1'b1;
        addr_a = 5'b00011;
        addr_b = 5'b11100;
        step();
        check_outs("midreset_held", 1'b0, 1'b0, 1'b0, 5'b00000);
        #2 rst = 1'b0;
        step();
        check_outs("post_reset_A", 1'b1, 1'b0, 1'b1, 5'b00011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
